// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file write-port owner.
// Extracts load data from the memory read word, and merges late
// multicycle (mul/div) results through a small FIFO onto the single
// write port. Publishes a mask of registers whose late result is queued.
module mem_wb_writeback #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int LATE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_waddr,
  input  logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_is_load,
  input  logic [2:0]             mem_load_type,
  input  logic [1:0]             mem_addr_lo,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   late_valid,
  output logic                   late_ready,
  input  logic [ADDR_W-1:0]      late_waddr,
  input  logic [DATA_W-1:0]      late_wdata,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [(1<<ADDR_W)-1:0] pend_mask
);

  localparam int PTR_W = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
  localparam int CNT_W = $clog2(LATE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LATE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LATE_DEPTH);

  // Little-endian load extraction; unknown encodings fall back to a full word.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] rdata,
    input logic [2:0]        ltype,
    input logic [1:0]        lo
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[8*lo +: 8];
    h = rdata[16*lo[1] +: 16];
    case (ltype)
      3'b000:  load_extract = DATA_W'(b);
      3'b100:  load_extract = DATA_W'($unsigned(b));
      3'b001:  load_extract = DATA_W'(h);
      3'b101:  load_extract = DATA_W'($unsigned(h));
      default: load_extract = rdata;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic              r_we_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_data_p1;

  logic [ADDR_W-1:0] r_q_addr [LATE_DEPTH];
  logic [DATA_W-1:0] r_q_data [LATE_DEPTH];
  logic [LATE_DEPTH-1:0] r_q_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic [DATA_W-1:0] w_mem_data;
  logic [(1<<ADDR_W)-1:0] w_pend;

  assign w_full     = (r_cnt == FULL_CNT);
  assign w_empty    = (r_cnt == '0);
  assign w_accept   = late_valid && !w_full;
  // Offers to x0 are acknowledged but never stored.
  assign w_push     = w_accept && (late_waddr != '0);
  // The pipe write owns the port whenever it is active, even while stalled.
  assign w_pop      = !r_we_p1 && !w_empty;
  assign w_mem_data = mem_is_load ? load_extract(mem_rdata, mem_load_type, mem_addr_lo)
                                  : mem_wdata;

  // MEM -> WB boundary: pipe register with rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else if (flush) begin
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else if (!stall) begin
      r_we_p1   <= mem_we && (mem_waddr != '0);
      r_addr_p1 <= mem_waddr;
      r_data_p1 <= w_mem_data;
    end
  end

  // Late-queue control: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_q_vld  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      // Pop and push never hit the same slot: a push needs the queue not full,
      // so a popped head slot is distinct from the tail slot being written.
      if (w_pop)  r_q_vld[r_rd_ptr] <= 1'b0;
      if (w_push) r_q_vld[r_wr_ptr] <= 1'b1;
    end
  end

  // Late-queue payload storage; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= late_waddr;
      r_q_data[r_wr_ptr] <= late_wdata;
    end
  end

  // Pending mask: OR of one-hot decodes of every valid queued destination.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < LATE_DEPTH; i++) begin
      if (r_q_vld[i]) w_pend[r_q_addr[i]] = 1'b1;
    end
  end

  // Write-port mux: pipe write first, then queue head, else idle zeros.
  always_comb begin
    wb_we   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    if (r_we_p1) begin
      wb_we   = 1'b1;
      wb_addr = r_addr_p1;
      wb_data = r_data_p1;
    end else if (!w_empty) begin
      wb_we   = 1'b1;
      wb_addr = r_q_addr[r_rd_ptr];
      wb_data = r_q_data[r_rd_ptr];
    end
  end

  assign late_ready = !w_full;
  assign pend_mask  = w_pend;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with hand-computed expectations.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_we, mem_is_load, late_valid;
  logic [4:0]  mem_waddr, late_waddr;
  logic [31:0] mem_wdata, mem_rdata, late_wdata;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic        late_ready, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] pend_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(32), .ADDR_W(5), .LATE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_is_load(mem_is_load), .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .late_valid(late_valid), .late_ready(late_ready),
    .late_waddr(late_waddr), .late_wdata(late_wdata),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_mask(pend_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   32'(wb_we), 32'd0);
    chk({tag, ".addr"}, 32'(wb_addr), 32'd0);
    chk({tag, ".data"}, wb_data, 32'd0);
    chk({tag, ".rdy"},  32'(late_ready), 32'd1);
    chk({tag, ".pend"}, pend_mask, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},   32'(wb_we), 32'd1);
    chk({tag, ".addr"}, 32'(wb_addr), 32'(a));
    chk({tag, ".data"}, wb_data, d);
  endtask

  logic [2:0]  ld_type [7];
  logic [1:0]  ld_lo   [7];
  logic [31:0] ld_exp  [7];

  initial begin
    ld_type[0] = 3'b000; ld_lo[0] = 2'd3; ld_exp[0] = 32'hFFFFFF80;
    ld_type[1] = 3'b100; ld_lo[1] = 2'd3; ld_exp[1] = 32'h00000080;
    ld_type[2] = 3'b001; ld_lo[2] = 2'd2; ld_exp[2] = 32'hFFFF80FF;
    ld_type[3] = 3'b101; ld_lo[3] = 2'd1; ld_exp[3] = 32'h00007F01;
    ld_type[4] = 3'b010; ld_lo[4] = 2'd3; ld_exp[4] = 32'h80FF7F01;
    ld_type[5] = 3'b000; ld_lo[5] = 2'd1; ld_exp[5] = 32'h0000007F;
    ld_type[6] = 3'b111; ld_lo[6] = 2'd2; ld_exp[6] = 32'h80FF7F01;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_is_load = 1'b0;
    mem_load_type = 3'b010; mem_addr_lo = '0; mem_rdata = '0;
    late_valid = 1'b0; late_waddr = '0; late_wdata = '0;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("idle");
    end

    // Plain capture, then a write to x0 that must be suppressed.
    mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h12345678;
    step();
    chk_wr("cap", 5'd3, 32'h12345678);
    mem_waddr = 5'd0;
    step();
    chk("x0.we", 32'(wb_we), 32'd0);
    chk("x0.addr", 32'(wb_addr), 32'd0);

    // Load extraction table.
    mem_waddr = 5'd1; mem_is_load = 1'b1; mem_rdata = 32'h80FF7F01;
    for (int i = 0; i < 7; i++) begin
      mem_load_type = ld_type[i]; mem_addr_lo = ld_lo[i];
      step();
      chk($sformatf("load%0d", i), wb_data, ld_exp[i]);
    end
    mem_is_load = 1'b0;

    // Late write queued behind three cycles of pipe writes to reg 7.
    mem_waddr = 5'd7; mem_wdata = 32'h77;
    step();
    chk_wr("busy1", 5'd7, 32'h77);
    late_valid = 1'b1; late_waddr = 5'd5; late_wdata = 32'hAA;
    step();
    late_valid = 1'b0;
    chk_wr("busy2", 5'd7, 32'h77);
    chk("late.pend", pend_mask, 32'h20);
    step();
    chk_wr("busy3", 5'd7, 32'h77);
    chk("late.pend3", pend_mask, 32'h20);
    mem_we = 1'b0;
    step();
    chk_wr("late.drain", 5'd5, 32'hAA);
    step();
    chk("late.pend0", pend_mask, 32'd0);
    chk("late.we0", 32'(wb_we), 32'd0);

    // Fill the queue while the pipe is busy; third offer must wait.
    mem_we = 1'b1; mem_waddr = 5'd7;
    step();
    late_valid = 1'b1; late_waddr = 5'd6; late_wdata = 32'h11;
    step();
    late_waddr = 5'd8; late_wdata = 32'h22;
    step();
    chk("full.rdy", 32'(late_ready), 32'd0);
    chk("full.pend", pend_mask, 32'h140);
    late_waddr = 5'd10; late_wdata = 32'h33;
    step();
    chk("held.rdy", 32'(late_ready), 32'd0);
    chk("held.pend", pend_mask, 32'h140);
    mem_we = 1'b0;
    step();
    chk_wr("head6", 5'd6, 32'h11);
    chk("head6.rdy", 32'(late_ready), 32'd0);
    step();
    chk("pop.rdy", 32'(late_ready), 32'd1);
    chk_wr("head8", 5'd8, 32'h22);
    step();
    late_valid = 1'b0;
    chk_wr("head10", 5'd10, 32'h33);
    chk("head10.pend", pend_mask, 32'h400);
    step();
    chk_idle("drained");

    // Flush turns a write into a bubble.
    mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h44; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.we", 32'(wb_we), 32'd0);

    // Stall repeats the held write and blocks queue pops.
    mem_waddr = 5'd9; mem_wdata = 32'h55;
    step();
    chk_wr("stall0", 5'd9, 32'h55);
    stall = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h0;
    late_valid = 1'b1; late_waddr = 5'd12; late_wdata = 32'hCC;
    step();
    late_valid = 1'b0;
    chk_wr("stall1", 5'd9, 32'h55);
    chk("stall1.pend", pend_mask, 32'h1000);
    step();
    chk_wr("stall2", 5'd9, 32'h55);
    chk("stall2.pend", pend_mask, 32'h1000);
    stall = 1'b0; mem_we = 1'b0;
    step();
    chk_wr("unstall", 5'd12, 32'hCC);
    step();
    chk_idle("unstall.idle");

    // Reset while the queue is full.
    mem_we = 1'b1; mem_waddr = 5'd7;
    step();
    late_valid = 1'b1; late_waddr = 5'd1; late_wdata = 32'h1;
    step();
    late_waddr = 5'd2; late_wdata = 32'h2;
    step();
    late_valid = 1'b0;
    chk("prerst.rdy", 32'(late_ready), 32'd0);
    rst = 1'b1; mem_we = 1'b0;
    step();
    rst = 1'b0;
    chk_idle("midrst");
    step();
    chk_idle("midrst.after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
